// File: rtl/tick_gen_mc_if.sv
// Control/status bundle for the multi-channel tick generator.
// The master side drives pause/restart/enables/speeds; the slave side returns the tick outputs.
interface tick_gen_mc_if #(
    parameter int N_CH   = 4,
    parameter int SPD_W  = 3,
    parameter int BEAT_W = 8
);
    logic                     pause;
    logic                     restart;
    logic [N_CH-1:0]          ch_en;
    logic [N_CH*SPD_W-1:0]    speed;
    logic                     base_tick;
    logic [N_CH-1:0]          clk_slow;
    logic [N_CH-1:0]          tick_out;
    logic [N_CH*BEAT_W-1:0]   beat_cnt;

    modport master (
        output pause, restart, ch_en, speed,
        input  base_tick, clk_slow, tick_out, beat_cnt
    );

    modport slave (
        input  pause, restart, ch_en, speed,
        output base_tick, clk_slow, tick_out, beat_cnt
    );
endinterface

// File: rtl/tick_gen_mc.sv
// Multi-channel tempo generator: a shared prescaler strobe is divided per channel
// into a square wave, a one-cycle tick on each rising edge, and a beat counter.
module tick_gen_mc #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 20,
    parameter int BASE_DIV = 721154,
    parameter int SPD_W    = 3,
    parameter int BEAT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    tick_gen_mc_if.slave  bus
);
    localparam logic [CNT_W-1:0] BASE_TC = CNT_W'(BASE_DIV);

    logic [CNT_W-1:0] pre_cnt;
    logic             base_tick_q;
    logic             base_stb;

    wire  [N_CH-1:0]        slow_vec;
    wire  [N_CH-1:0]        tick_vec;
    wire  [N_CH*BEAT_W-1:0] beat_vec;

    // Restart and pause both suppress the strobe so no channel can advance on those cycles.
    assign base_stb = (pre_cnt == BASE_TC) && !bus.pause && !bus.restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            base_tick_q <= base_stb;
            if (bus.restart || base_stb) begin
                pre_cnt <= '0;
            end else if (!bus.pause) begin
                pre_cnt <= pre_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SPD_W-1:0]  slow_cnt;
        logic [SPD_W-1:0]  spd_sh;
        logic [BEAT_W-1:0] beats;
        logic              slow_q;
        logic              tick_q;
        logic [SPD_W-1:0]  spd_in;
        logic              wrap;

        assign spd_in = bus.speed[i*SPD_W +: SPD_W];
        // Comparing against the shadow, not the live input, keeps a mid-period speed change from shortening or overrunning the count.
        assign wrap   = base_stb && (slow_cnt == spd_sh);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slow_cnt <= '0;
                spd_sh   <= '0;
                beats    <= '0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else if (bus.restart) begin
                slow_cnt <= '0;
                spd_sh   <= spd_in;
                beats    <= '0;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else if (!bus.ch_en[i]) begin
                slow_cnt <= '0;
                spd_sh   <= spd_in;
                slow_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                tick_q <= wrap && !slow_q;
                if (wrap) begin
                    slow_cnt <= '0;
                    slow_q   <= !slow_q;
                    spd_sh   <= spd_in;
                    if (!slow_q) begin
                        beats <= beats + BEAT_W'(1);
                    end
                end else if (base_stb) begin
                    slow_cnt <= slow_cnt + SPD_W'(1);
                end
            end
        end

        assign slow_vec[i]                 = slow_q;
        assign tick_vec[i]                 = tick_q;
        assign beat_vec[i*BEAT_W +: BEAT_W] = beats;
    end

    assign bus.base_tick = base_tick_q;
    assign bus.clk_slow  = slow_vec;
    assign bus.tick_out  = tick_vec;
    assign bus.beat_cnt  = beat_vec;
endmodule

// File: tb/tb_tick_gen_mc.sv
// Directed bench for tick_gen_mc with a short prescaler (BASE_DIV=3) and 2-bit beat counters.
// "Cycle n" means the values sampled 1 time unit after the n-th rising edge following reset.
module tb_tick_gen_mc;
    localparam int N_CH     = 2;
    localparam int CNT_W    = 4;
    localparam int BASE_DIV = 3;
    localparam int SPD_W    = 3;
    localparam int BEAT_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    tick_gen_mc_if #(.N_CH(N_CH), .SPD_W(SPD_W), .BEAT_W(BEAT_W)) bus ();

    tick_gen_mc #(
        .N_CH(N_CH), .CNT_W(CNT_W), .BASE_DIV(BASE_DIV), .SPD_W(SPD_W), .BEAT_W(BEAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic p, input logic r, input logic [1:0] en,
                                 input logic [2:0] spd0, input logic [2:0] spd1);
        bus.pause   = p;
        bus.restart = r;
        bus.ch_en   = en;
        bus.speed   = {spd1, spd0};
    endtask

    // Reset pulse lands between edges so the following edge is cycle 1.
    task automatic applyReset(input logic [1:0] en, input logic [2:0] spd0, input logic [2:0] spd1);
        applyStimulus(1'b0, 1'b0, en, spd0, spd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Basic timing: speed0=1, speed1=0.
        applyReset(2'b11, 3'd1, 3'd0);
        checkOutput("rst_state", {31'd0, bus.base_tick} | {25'd0, bus.clk_slow, bus.tick_out, bus.beat_cnt}, 32'd0);
        for (int c = 1; c <= 36; c++) begin
            step(1);
            checkOutput("base_tick", {31'd0, bus.base_tick}, {31'd0, (cyc % 4) == 0});
            checkOutput("tick0", {31'd0, bus.tick_out[0]}, {31'd0, (cyc == 4) || (cyc == 20) || (cyc == 36)});
            checkOutput("tick1", {31'd0, bus.tick_out[1]}, {31'd0, (cyc % 8) == 4});
            if (cyc == 4)  checkOutput("t1_c4",  {24'd0, bus.clk_slow, bus.beat_cnt, bus.tick_out}, {24'd0, 2'b11, 4'b0101, 2'b11});
            if (cyc == 12) checkOutput("t1_c12", {26'd0, bus.clk_slow, bus.beat_cnt}, {26'd0, 2'b10, 4'b1001});
            if (cyc == 20) checkOutput("t1_c20", {26'd0, bus.clk_slow, bus.beat_cnt}, {26'd0, 2'b11, 4'b1110});
            if (cyc == 36) checkOutput("t1_c36", {26'd0, bus.clk_slow, bus.beat_cnt}, {26'd0, 2'b11, 4'b0111});
        end

        // Mid-period speed change 3 -> 0 while slow_cnt0 = 2.
        applyReset(2'b11, 3'd3, 3'd0);
        step(12);
        checkOutput("t2_c12_clk0", {31'd0, bus.clk_slow[0]}, 32'd1);
        bus.speed[2:0] = 3'd0;
        for (int c = 13; c <= 32; c++) begin
            step(1);
            checkOutput("t2_clk0", {31'd0, bus.clk_slow[0]},
                        {31'd0, (cyc < 20) || (cyc >= 24 && cyc < 28) || (cyc >= 32)});
            checkOutput("t2_tick0", {31'd0, bus.tick_out[0]}, {31'd0, (cyc == 24) || (cyc == 32)});
        end

        // Pause for 10 cycles starting with pre_cnt = 1 and both clk_slow high.
        applyReset(2'b11, 3'd1, 3'd0);
        step(4);
        checkOutput("t3_bt4", {31'd0, bus.base_tick}, 32'd1);
        step(1);
        bus.pause = 1'b1;
        for (int c = 6; c <= 15; c++) begin
            step(1);
            checkOutput("t3_frozen", {23'd0, bus.base_tick, bus.tick_out, bus.clk_slow, bus.beat_cnt},
                        {23'd0, 1'b0, 2'b00, 2'b11, 4'b0101});
        end
        bus.pause = 1'b0;
        step(2);
        checkOutput("t3_bt17", {31'd0, bus.base_tick}, 32'd0);
        step(1);
        checkOutput("t3_c18", {29'd0, bus.base_tick, bus.clk_slow}, {29'd0, 1'b1, 2'b01});
        step(4);
        checkOutput("t3_c22", {23'd0, bus.base_tick, bus.clk_slow, bus.tick_out, bus.beat_cnt},
                    {23'd0, 1'b1, 2'b10, 2'b10, 4'b1001});

        // Restart with channels at different phases; equal speeds then tick together.
        applyReset(2'b01, 3'd1, 3'd1);
        step(5);
        bus.ch_en = 2'b11;
        step(7);
        checkOutput("t4_pre", {24'd0, bus.clk_slow, bus.tick_out, bus.beat_cnt}, {24'd0, 2'b10, 2'b10, 4'b0101});
        step(1);
        bus.restart = 1'b1;
        step(1);
        bus.restart = 1'b0;
        checkOutput("t4_restart", {23'd0, bus.base_tick, bus.clk_slow, bus.tick_out, bus.beat_cnt}, 32'd0);
        for (int c = 15; c <= 21; c++) begin
            step(1);
            checkOutput("t4_tick", {30'd0, bus.tick_out}, 32'd0);
            checkOutput("t4_bt", {31'd0, bus.base_tick}, {31'd0, cyc == 18});
        end
        step(1);
        checkOutput("t4_c22", {24'd0, bus.clk_slow, bus.tick_out, bus.beat_cnt}, {24'd0, 2'b11, 2'b11, 4'b0101});

        // Channel 1 disabled for 20 cycles; first wrap after re-enable raises clk_slow[1].
        applyReset(2'b11, 3'd0, 3'd1);
        step(20);
        checkOutput("t5_c20", {29'd0, bus.tick_out[1], bus.beat_cnt[3:2]}, {29'd0, 1'b1, 2'd2});
        step(1);
        bus.ch_en = 2'b01;
        for (int c = 22; c <= 41; c++) begin
            step(1);
            checkOutput("t5_off", {28'd0, bus.clk_slow[1], bus.tick_out[1], bus.beat_cnt[3:2]}, {28'd0, 4'b0010});
        end
        bus.ch_en = 2'b11;
        step(3);
        checkOutput("t5_ch0_c44", {29'd0, bus.tick_out[0], bus.beat_cnt[1:0]}, {29'd0, 1'b1, 2'd2});
        step(3);
        checkOutput("t5_c47", {30'd0, bus.clk_slow[1], bus.tick_out[1]}, 32'd0);
        step(1);
        checkOutput("t5_c48", {28'd0, bus.clk_slow[1], bus.tick_out[1], bus.beat_cnt[3:2]}, {28'd0, 4'b1111});

        // Beat counter wrap, then restart coincident with pause and a would-be tick strobe.
        applyReset(2'b11, 3'd0, 3'd0);
        step(4);
        checkOutput("t6_beat", {30'd0, bus.beat_cnt[1:0]}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step(8);
            checkOutput("t6_beat", {30'd0, bus.beat_cnt[1:0]}, 32'((k + 1) % 4));
        end
        step(7);
        checkOutput("t6_c43_clk0", {31'd0, bus.clk_slow[0]}, 32'd0);
        bus.pause   = 1'b1;
        bus.restart = 1'b1;
        step(1);
        bus.pause   = 1'b0;
        bus.restart = 1'b0;
        checkOutput("t6_restart", {23'd0, bus.base_tick, bus.clk_slow, bus.tick_out, bus.beat_cnt}, 32'd0);
        step(1);
        checkOutput("t6_bt45", {31'd0, bus.base_tick}, 32'd0);
        step(3);
        checkOutput("t6_c48", {28'd0, bus.base_tick, bus.tick_out[0], bus.beat_cnt[1:0]}, {28'd0, 4'b1101});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
